// File: rtl/core_pkg.sv
// core_pkg: constants shared by the fetch path and the instruction memory.
//   BASE_ADDRESS / RESET_PC : instruction memory base, first fetch address after reset
//   NOP_INSTRUCTION         : word the memory returns for out-of-range or misaligned reads
//   fetch_entry_t           : one buffered fetch, {instruction, pc}
package core_pkg;

  localparam logic [31:0] BASE_ADDRESS    = 32'h0100_0000;
  localparam logic [31:0] RESET_PC        = BASE_ADDRESS;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h1111_1111;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: bundles the fetch controller's core-side and memory-side signals.
//   fetchEnable/redirectValid/redirectTarget : control from the core
//   imemReadEnable/imemAddress/imemInstruction : synchronous instruction memory read port
//   fetchValid/fetchInstruction/fetchPc/decodeReady : valid/ready handshake to decode
// The master modport is the fetch controller; slave is the surrounding core/memory.
interface fetch_controller_if;

  logic        fetchEnable;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        imemReadEnable;
  logic [31:0] imemAddress;
  logic [31:0] imemInstruction;
  logic        fetchValid;
  logic [31:0] fetchInstruction;
  logic [31:0] fetchPc;
  logic        decodeReady;

  modport master (
    input  fetchEnable, redirectValid, redirectTarget, imemInstruction, decodeReady,
    output imemReadEnable, imemAddress, fetchValid, fetchInstruction, fetchPc
  );

  modport slave (
    output fetchEnable, redirectValid, redirectTarget, imemInstruction, decodeReady,
    input  imemReadEnable, imemAddress, fetchValid, fetchInstruction, fetchPc
  );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {instruction, pc} fetch entries.
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : drop all entries (wins over push/pop in the same cycle)
//   push_i/push_data_i : write one entry; caller guarantees the FIFO is not full
//   pop_i        : retire the head entry; push and pop may coincide at any count
//   head_o       : head entry, all-zero while empty
//   count_o      : number of valid entries, 0..2
module fetch_buffer
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // Zero while empty so stale words never show on the decode side.
  assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer between PC logic and a 1-cycle-latency
// synchronous instruction memory.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_controller_if.master (core control, memory read port, decode handshake)
// Owns the PC, issues at most one read per cycle while the 2-entry buffer plus the
// in-flight read leave room, captures every returned word, and flushes on redirect.
module fetch_controller #(
  parameter logic [31:0] RESET_PC        = core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTRUCTION = core_pkg::NOP_INSTRUCTION
) (
  input  logic clk,
  input  logic reset,
  fetch_controller_if.master bus
);

  logic [31:0]            pc_q;
  logic [31:0]            inflight_pc_q;
  logic                   inflight_q;
  logic                   squash_q;
  logic [1:0]             count;
  core_pkg::fetch_entry_t head;
  core_pkg::fetch_entry_t push_data;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic [2:0]             occupancy;
  logic                   unused_params;

  // The memory supplies NOP words itself; this block only passes them through.
  assign unused_params = ^NOP_INSTRUCTION;

  assign pop = bus.fetchValid && bus.decodeReady;

  // Buffered plus in-flight words after this cycle's pop; issuing needs a free slot
  // for the word that will return next cycle.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = !reset && bus.fetchEnable && !bus.redirectValid && (occupancy < 3'd2);

  assign push            = inflight_q && !squash_q;
  assign push_data.instr = bus.imemInstruction;
  assign push_data.pc    = inflight_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      squash_q      <= 1'b0;
    end else if (bus.redirectValid) begin
      pc_q       <= bus.redirectTarget;
      inflight_q <= 1'b0;
      squash_q   <= inflight_q;
    end else begin
      inflight_q <= issue;
      squash_q   <= 1'b0;
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
    end
  end

  // Redirect flushes the buffer and also drops the word returning this cycle.
  fetch_buffer u_fetch_buffer (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redirectValid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imemReadEnable   = issue;
  assign bus.imemAddress      = pc_q;
  assign bus.fetchValid       = (count != 2'd0);
  assign bus.fetchInstruction = head.instr;
  assign bus.fetchPc          = head.pc;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer between the core's program counter logic and the synchronous instruction memory. It owns the PC and drives the memory's read port, including readEnable, address and the one-cycle read latency. Returned words are captured into a 2-entry buffer so fetch data is never lost when decode stalls. Branch/jump redirects from execute flush in-flight and buffered fetches.

## Interface
- `RESET_PC`, default 32'h01000000: first fetch address after reset (instruction memory base).
- `NOP_INSTRUCTION`, default 32'h11111111: memory's out-of-range/idle word; passed through, never generated here.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `fetchEnable` in 1: 0 = issue no new reads; in-flight read still completes and is buffered.
- `redirectValid` in 1: one-cycle pulse; load PC with `redirectTarget`, flush.
- `redirectTarget` in 32: new fetch address.
- `imemReadEnable` out 1: memory read strobe.
- `imemAddress` out 32: memory read address.
- `imemInstruction` in 32: memory data, valid the cycle after a read is issued.
- `fetchValid` out 1: `fetchInstruction`/`fetchPc` hold a valid fetch.
- `fetchInstruction` out 32: fetched word.
- `fetchPc` out 32: address that word was fetched from.
- `decodeReady` in 1: decode accepts when `fetchValid && decodeReady`.

## Operation
- Registers: `pc` (next issue address), `inflight` (read issued last cycle), `inflightPc`, `squash` (discard the in-flight return), 2-entry buffer with `count` 0..2.
- Issue condition (combinational): `!reset && fetchEnable && !redirectValid && (count + inflight - pop) < 2`, where `pop = fetchValid && decodeReady`.
- On issue: `imemReadEnable=1`, `imemAddress=pc`, `pc <= pc+4`, `inflight <= 1`, `inflightPc <= pc`. Otherwise `imemReadEnable=0` and `inflight <= 0`.
- PC arithmetic: 32-bit, wraps modulo 2^32. No alignment check here; misaligned/out-of-range addresses return `NOP_INSTRUCTION` from memory and are delivered normally.
- Capture: when `inflight && !squash`, push `{imemInstruction, inflightPc}` into the buffer. When `inflight && squash`, drop the word. `squash` clears after one cycle.
- Buffer: FIFO order. Simultaneous push and pop is allowed at any count, including count=2 with pop. The issue rule guarantees no push to a full buffer.
- Redirect (highest priority): `pc <= redirectTarget`, `count <= 0`, `squash <= inflight`, no issue in that cycle. A pop in the same cycle completes the handshake, but the entry is flushed anyway.
- `fetchEnable` low: issuing stops and buffered entries drain normally. A redirect while disabled still updates `pc` and flushes.
- Reset has priority over everything: `pc=RESET_PC`, `count=0`, `inflight=0`, `squash=0`.
- Outputs after reset: `fetchValid=0`, `fetchInstruction=0`, `fetchPc=0`, `imemReadEnable=0`, `imemAddress=RESET_PC`.

## Timing
- Memory contract: address/readEnable sampled at edge N, data valid during cycle N+1 only. The word is not held, so capture is mandatory in that cycle.
- After reset deasserts, the first issue is in cycle 1 (`imemAddress=RESET_PC`). Data arrives in cycle 2, and `fetchValid=1` in cycle 3.
- Redirect pulse in cycle t: issue of the target in t+1, `fetchValid` with `fetchPc=target` in t+3. Nothing from before the redirect is visible after t.
- Steady state with `decodeReady=1`: one instruction per cycle, with consecutive `fetchPc` values incrementing by 4.
- Stall: while `fetchValid && !decodeReady`, all fetch outputs are held stable. At most 2 words are buffered, and issue resumes in the same cycle `decodeReady` rises.
- Reset mid-operation: all in-flight and buffered data is discarded; the sequence restarts as after power-up.

## Structure
- Shared package `core_pkg`: `RESET_PC`/`BASE_ADDRESS` (32'h01000000) and `NOP_INSTRUCTION` (32'h11111111), also used by the instruction memory.
- Sub-module `fetch_buffer`: 2-entry, 64-bit-wide synchronous FIFO with push/pop/count, flush input and synchronous active-high reset.
- Top level holds `pc`/`inflight`/`squash` and the issue logic.

## Test plan
- Reset, `fetchEnable=1`, `decodeReady=1`, memory preloaded with i*0x10 at word i:
  - `fetchValid` first rises in cycle 3 with `fetchPc=01000000`.
  - Then one fetch per cycle: 01000004, 01000008, …
- Hold `decodeReady=0` for 5 cycles mid-stream:
  - Outputs stay frozen.
  - `imemReadEnable` stops after 2 outstanding words.
  - On release, no PC is skipped or duplicated.
- Redirect to 01000100 while the buffer is full and a read is in flight:
  - `fetchPc` 01000100 appears exactly 3 cycles later.
  - No pre-redirect word appears after the pulse.
- Redirect to 02000000 (outside memory) and to 01000002 (misaligned): `fetchInstruction=11111111` with the matching `fetchPc`.
- `fetchEnable` deasserted with count=1 and inflight=1: both words are delivered, then `fetchValid=0` and `imemReadEnable` stays 0.
- Assert `reset` for one cycle mid-stream with the buffer full: outputs return to reset values and the fetch sequence restarts at 01000000.
